// File: rtl/keypad_scan_if.sv
// Keypad port bundle: row returns in, column strobes and debounced key report out.
interface keypad_scan_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column strobing, frame accumulation and
// press/release debounce, reporting one key code per accepted press.
module keypad_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic           clk,
    input logic           rst,
    keypad_scan_if.master kp
);

    localparam int             PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PMAX = PW'(SCAN_DIV - 1);
    localparam logic [3:0]     DMAX = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    // Adds the pressed rows of one column sample to the frame count,
    // saturating at 2 since only NONE/SINGLE/MULTI is ever needed.
    function automatic logic [1:0] sat_add(input logic [1:0] cnt, input logic [3:0] pr);
        logic [2:0] sum;
        sum = {1'b0, cnt} + 3'(pr[0]) + 3'(pr[1]) + 3'(pr[2]) + 3'(pr[3]);
        return (sum >= 3'd2) ? 2'd2 : sum[1:0];
    endfunction

    function automatic logic [3:0] first_code(input logic [3:0] pr, input logic [1:0] c);
        logic [3:0] code;
        code = {2'b00, c};
        for (int r = 3; r >= 0; r--) begin
            if (pr[r]) code = {2'(r), c};
        end
        return code;
    endfunction

    logic [3:0]    row_p0, row_p1;
    logic [PW-1:0] presc;
    logic [1:0]    col;
    logic [3:0]    col_reg;
    logic          tick;

    logic [1:0]    acc_cnt;
    logic [3:0]    acc_code;
    logic [15:0]   acc_map;
    logic [3:0]    pressed;
    logic [15:0]   smap;
    logic [1:0]    cnt_s;
    logic [3:0]    code_s;
    logic [15:0]   map_s;

    logic          frm_vld_p2;
    logic [1:0]    frm_cnt_p2;
    logic [3:0]    frm_code_p2;
    logic [15:0]   frm_map_p2;

    state_t        state;
    logic [3:0]    dcnt;
    logic [3:0]    cand;
    logic [3:0]    key_reg;
    logic          valid_reg;
    logic          held_reg;
    logic          single;
    logic          hit;

    // Stage p0/p1: two-flop synchronizer, idles at released (all ones)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_p0 <= 4'hF;
            row_p1 <= 4'hF;
        end else begin
            row_p0 <= kp.row_in;
            row_p1 <= row_p0;
        end
    end

    assign tick = (presc == PMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            col     <= 2'd0;
            col_reg <= 4'b1110;
        end else if (tick) begin
            presc   <= '0;
            col     <= col + 2'd1;
            col_reg <= ~(4'b0001 << (col + 2'd1));
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign pressed = ~row_p1;

    always_comb begin
        smap = '0;
        for (int r = 0; r < 4; r++) begin
            smap[{2'(r), col}] = pressed[r];
        end
    end

    assign cnt_s  = sat_add(acc_cnt, pressed);
    assign code_s = (|pressed) ? first_code(pressed, col) : acc_code;
    assign map_s  = acc_map | smap;

    // The column-3 sample is folded straight into the frame result,
    // so the accumulator can restart cleanly on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt    <= 2'd0;
            acc_code   <= 4'd0;
            acc_map    <= '0;
            frm_vld_p2 <= 1'b0;
        end else begin
            frm_vld_p2 <= tick && (col == 2'd3);
            if (tick) begin
                if (col == 2'd3) begin
                    acc_cnt  <= 2'd0;
                    acc_code <= 4'd0;
                    acc_map  <= '0;
                end else begin
                    acc_cnt  <= cnt_s;
                    acc_code <= code_s;
                    acc_map  <= map_s;
                end
            end
        end
    end

    // Stage p2: completed frame summary
    always_ff @(posedge clk) begin
        if (tick && (col == 2'd3)) begin
            frm_cnt_p2  <= cnt_s;
            frm_code_p2 <= code_s;
            frm_map_p2  <= map_s;
        end
    end

    assign single = (frm_cnt_p2 == 2'd1);
    assign hit    = frm_map_p2[key_reg];

    // Hold detection uses the full position map so a MULTI frame that
    // still contains the accepted key keeps it down (rollover lockout).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dcnt      <= 4'd0;
            cand      <= 4'd0;
            key_reg   <= 4'd0;
            valid_reg <= 1'b0;
            held_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (frm_vld_p2) begin
                case (state)
                    IDLE: begin
                        if (single) begin
                            cand <= frm_code_p2;
                            dcnt <= 4'd1;
                            if (DMAX == 4'd1) begin
                                key_reg   <= frm_code_p2;
                                valid_reg <= 1'b1;
                                held_reg  <= 1'b1;
                                state     <= PRESSED;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (!single) begin
                            dcnt  <= 4'd0;
                            state <= IDLE;
                        end else if (frm_code_p2 != cand) begin
                            cand <= frm_code_p2;
                            dcnt <= 4'd1;
                        end else if (dcnt + 4'd1 == DMAX) begin
                            dcnt      <= dcnt + 4'd1;
                            key_reg   <= cand;
                            valid_reg <= 1'b1;
                            held_reg  <= 1'b1;
                            state     <= PRESSED;
                        end else begin
                            dcnt <= dcnt + 4'd1;
                        end
                    end
                    PRESSED: begin
                        if (!hit) begin
                            dcnt <= 4'd1;
                            if (DMAX == 4'd1) begin
                                held_reg <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (hit) begin
                            state <= PRESSED;
                        end else if (dcnt + 4'd1 == DMAX) begin
                            dcnt     <= dcnt + 4'd1;
                            held_reg <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            dcnt <= dcnt + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign kp.col_out   = col_reg;
    assign kp.key_code  = key_reg;
    assign kp.key_valid = valid_reg;
    assign kp.key_held  = held_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: frame-level key stimulus, key-press reference model
// and a scoreboard that matches every key_valid pulse (code and cycle).
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DB = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_scan_if kp();

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk(clk),
        .rst(rst),
        .kp (kp)
    );

    // Physical matrix: a pressed key at (r,c) pulls row r low while column c is strobed
    logic [15:0] keys = 16'h0000;
    logic [3:0]  rows;
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            rows[r] = ~|(keys[r*4 +: 4] & ~kp.col_out);
        end
    end
    assign kp.row_in = rows;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;
    exp_t expq[$];

    int checks = 0;
    int errors = 0;
    int cyc;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && kp.key_valid) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: actual code=%0d at cycle %0d, required no pulse",
                         kp.key_code, cyc);
            end else begin
                e = expq.pop_front();
                if (kp.key_code !== e.code || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse: actual code=%0d cycle=%0d, required code=%0d cycle=%0d",
                             kp.key_code, cyc, e.code, e.cyc);
                end
            end
        end
    end

    // Reference model: one call per full frame of a constant key set
    bit         m_held;
    logic [3:0] m_acc;
    logic [3:0] m_cand;
    int         m_run;
    int         m_rel;
    int         fidx;

    task automatic model_reset();
        m_held = 1'b0;
        m_acc  = 4'd0;
        m_cand = 4'd0;
        m_run  = 0;
        m_rel  = 0;
        fidx   = 0;
    endtask

    task automatic model_frame(input logic [15:0] m);
        int         n;
        logic [3:0] c;
        n = $countones(m);
        c = 4'd0;
        for (int i = 0; i < 16; i++) if (m[i]) c = 4'(i);
        fidx++;
        if (m_held) begin
            if (m[m_acc]) begin
                m_rel = 0;
            end else begin
                m_rel++;
                if (m_rel == DB) begin
                    m_held = 1'b0;
                    m_run  = 0;
                end
            end
        end else if (n == 1) begin
            if (m_run > 0 && c == m_cand) m_run++;
            else begin
                m_cand = c;
                m_run  = 1;
            end
            if (m_run == DB) begin
                m_held = 1'b1;
                m_acc  = c;
                m_rel  = 0;
                m_run  = 0;
                expq.push_back('{code: c, cyc: 16 * fidx + 1});
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Applies a key set for one whole frame; also checks the column walk and
    // the held/code outputs resulting from the previous frame.
    task automatic run_frame(input logic [15:0] m);
        bit         hb;
        logic [3:0] ab;
        logic [3:0] ec;
        hb = m_held;
        ab = m_acc;
        keys = m;
        model_frame(m);
        for (int k = 0; k < 4; k++) begin
            ec = ~(4'b0001 << k);
            check("col_out", kp.col_out, ec);
            repeat (SD) @(posedge clk);
            #1;
        end
        check("key_held", kp.key_held, hb);
        check("key_code", kp.key_code, ab);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_col_out", kp.col_out, 4'b1110);
        check("rst_key_code", kp.key_code, 4'd0);
        check("rst_key_valid", kp.key_valid, 1'b0);
        check("rst_key_held", kp.key_held, 1'b0);
        check("pending_at_reset", expq.size(), 0);
        expq.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic [15:0] prev;
    logic [15:0] m;
    int          sel;

    initial begin
        model_reset();
        #23;
        do_reset();

        repeat (2) run_frame(16'h0000);

        // clean press of key 10, then release
        repeat (3) run_frame(16'h0001 << 10);
        repeat (3) run_frame(16'h0000);

        // asynchronous reset while a key is held
        repeat (3) run_frame(16'h0001 << 10);
        repeat (2) @(posedge clk);
        #3;
        do_reset();

        // bounce on key 5, then steady
        for (int i = 0; i < 6; i++) run_frame((i % 2 == 0) ? (16'h0001 << 5) : 16'h0000);
        repeat (3) run_frame(16'h0001 << 5);
        repeat (3) run_frame(16'h0000);

        // rollover: 10 held, 3 added, 10 released
        repeat (3) run_frame(16'h0001 << 10);
        repeat (2) run_frame((16'h0001 << 10) | (16'h0001 << 3));
        repeat (4) run_frame(16'h0001 << 3);
        repeat (3) run_frame(16'h0000);

        // two keys together from idle
        repeat (3) run_frame((16'h0001 << 1) | (16'h0001 << 6));
        run_frame(16'h0000);

        // reset in the middle of a debounce
        run_frame(16'h0001 << 7);
        repeat (5) @(posedge clk);
        #3;
        do_reset();
        repeat (3) run_frame(16'h0001 << 7);
        repeat (3) run_frame(16'h0000);

        // randomized frames
        prev = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       m = 16'h0000;
                1:       m = 16'h0001 << $urandom_range(0, 15);
                2:       m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                default: m = prev;
            endcase
            run_frame(m);
            prev = m;
        end
        repeat (3) run_frame(16'h0000);

        check("missing_pulses", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix keypad reader for the display board: drives active-low column strobes across a 4x4 key matrix and reads the active-low row returns. It debounces the result and reports one debounced key code per press. It is the input-side counterpart of the multiplexed digit scanner and runs from the same single system clock. Its outputs feed the counter/time-set logic alongside the display path.

## Interface
- `SCAN_DIV`, default 50000: system clocks per column step; one step is 1 ms at 50 MHz.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full-matrix frames required to accept a press or a release. Legal range 1..15.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `row_in`  in  4  row returns, active-low, externally pulled up, asynchronous to `clk`.
- `col_out`  out  4  column strobes, active-low, one-hot-zero.
- `key_code`  out  4  code of the last accepted key: row*4 + col.
- `key_valid`  out  1  one-clock pulse when a new debounced press is accepted.
- `key_held`  out  1  high while the accepted key is considered down.

## Operation
- **Synchronizer:** `row_in` passes through a 2-flop synchronizer before any use.
- **Prescaler:** counts 0..SCAN_DIV-1 and wraps. `tick` = (prescaler == SCAN_DIV-1).
- **Column sequence:**
  - Column index `col` runs 0→1→2→3→0 and advances on `tick`.
  - `col_out` = ~(1 << col).
- **Row sampling:**
  - On `tick`, the synchronized rows are sampled for the current column before the column advances, giving SCAN_DIV-1 clocks of settling.
  - Samples accumulate into a frame: number of pressed positions (saturating at 2) and the position code of the pressed key.
- **Frame end:** the `tick` with col==3 ends a frame. The frame is classified as NONE, SINGLE(code) or MULTI, and the accumulator clears for the next frame.
- **State machine.** States: IDLE, DEBOUNCE, PRESSED, RELEASE. A 4-bit frame counter `dcnt` tracks consecutive frames. It is evaluated once per frame:
  - **IDLE**
    - SINGLE(c): store candidate c, dcnt=1; go to DEBOUNCE, or directly to PRESSED if DEBOUNCE_SCANS==1.
    - NONE or MULTI: stay.
  - **DEBOUNCE**
    - SINGLE(same c): dcnt++. On reaching DEBOUNCE_SCANS: latch `key_code`=c, pulse `key_valid`, go to PRESSED.
    - SINGLE(different c'): candidate=c', dcnt=1.
    - NONE or MULTI: go to IDLE.
  - **PRESSED**
    - Any frame containing the accepted code (SINGLE or MULTI): stay.
    - Otherwise: dcnt=1, go to RELEASE.
  - **RELEASE**
    - Frame without the accepted code: dcnt++. On reaching DEBOUNCE_SCANS: go to IDLE.
    - Frame with the accepted code: return to PRESSED with no new `key_valid`.
- **`key_held`** = state is PRESSED or RELEASE.
- **Rollover:** a second key pressed while one is held is ignored. It is recognised only after the full release and a fresh debounce.

## Timing
- **Reset values:** `col_out`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0. Prescaler, col, dcnt and accumulator are 0; state is IDLE; synchronizer flops are 1 (released).
- **Reset mid-operation:** everything returns to reset values asynchronously. No `key_valid` is produced for a press in progress.
- **Frame evaluation:** registered on the clock after the col==3 `tick`. `key_valid` and `key_code` update on that same edge, and `key_code` holds until the next accepted press.
- **Frame length:** 4*SCAN_DIV clocks.
- **Press latency:** a press stable from the start of a frame gives `key_valid` DEBOUNCE_SCANS frames later, plus 1 clock.
- **`key_held` release:** deasserts DEBOUNCE_SCANS frames after the first key-free frame.
- **Row change landing:** a row change landing within 2 clocks of a `tick` may fall in either frame. The debounce count absorbs this.
- **Prescaler wrap:** SCAN_DIV-1 → 0 with no idle cycle.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2, so one frame = 16 clocks.

1. **Reset:** assert `rst` asynchronously mid-cycle. Required: `col_out`=1110, `key_code`=0, `key_valid`=0, `key_held`=0. After release, `col_out` steps 1110→1101→1011→0111 every 4 clocks.
2. **Clean press:** hold row 2 low only while `col_out`==1011 (key 10) for 3 frames. Required: exactly one `key_valid` pulse with `key_code`=10 about 2 frames + 1 clock after the press starts, and `key_held`=1.
3. **Bounce:** toggle key 5 on alternate frames for 6 frames, then hold. Required: no `key_valid` during toggling, then one pulse with code 5 after 2 steady frames.
4. **Release and rollover:** hold key 10, add key 3, release key 10, keep key 3. Required: no pulse while 10 is held; `key_held` drops after 2 key-10-free frames; then a new pulse with code 3.
5. **Multi-key:** press keys 1 and 6 together from IDLE. Required: no `key_valid`; state stays IDLE.
6. **Reset mid-debounce:** assert `rst` after 1 frame of key 7. Required: no pulse; after release, 2 fresh frames are needed before the code-7 pulse.
